// File: rtl/ordered_path_merge_pkg.sv
// Shared types and constants for the check/bypass path merge stage.
package ordered_path_merge_pkg;

    typedef struct packed {
        logic [15:0] flow_id;
        logic [15:0] pkt_len;
        logic [7:0]  rule_cnt;
        logic [7:0]  flags;
    } metadata_t;

    localparam logic PATH_CHECK  = 1'b0;
    localparam logic PATH_BYPASS = 1'b1;

    localparam int DATA_W_DEF  = 512;
    localparam int EMPTY_W_DEF = 6;
    localparam int META_W_DEF  = $bits(metadata_t);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    // Statistics counters roll over silently; callers rely on natural 32-bit wrap.
    function automatic logic [31:0] wrap_inc(input logic [31:0] value);
        return value + 32'd1;
    endfunction

endpackage

// File: rtl/ordered_path_merge_if.sv
// Valid/ready stream bundle used for packet, metadata and rule channels.
interface ordered_path_merge_if
    import ordered_path_merge_pkg::*;
#(
    parameter int DW = DATA_W_DEF,
    parameter int EW = EMPTY_W_DEF
);

    logic [DW-1:0] data;
    logic          valid;
    logic          ready;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;

    modport master (output data, valid, sop, eop, empty, input ready);
    modport slave  (input data, valid, sop, eop, empty, output ready);

endinterface

// File: rtl/ordered_path_merge_path_mux_ch.sv
// Selects one channel from the check or bypass source, gated by active,
// and flags the handshake that completes the channel for this packet.
module ordered_path_merge_path_mux_ch
    import ordered_path_merge_pkg::*;
#(
    parameter int W         = DATA_W_DEF,
    parameter int EW        = EMPTY_W_DEF,
    parameter bit HAS_FRAME = 1'b1
) (
    input  logic                 sel,
    input  logic                 active,
    ordered_path_merge_if.slave  src_check,
    ordered_path_merge_if.slave  src_bypass,
    ordered_path_merge_if.master dst,
    output logic                 fire,
    output logic                 done
);

    logic [W-1:0]  data_mux;
    logic [EW-1:0] empty_mux;
    logic          use_bypass;

    assign use_bypass = (sel == PATH_BYPASS);

    assign data_mux  = use_bypass ? src_bypass.data  : src_check.data;
    assign empty_mux = use_bypass ? src_bypass.empty : src_check.empty;

    assign dst.data  = data_mux;
    assign dst.empty = empty_mux;
    assign dst.sop   = use_bypass ? src_bypass.sop : src_check.sop;
    assign dst.eop   = use_bypass ? src_bypass.eop : src_check.eop;
    assign dst.valid = active & (use_bypass ? src_bypass.valid : src_check.valid);

    // The path that is not selected never sees ready, so its data stays put.
    assign src_check.ready  = active & ~use_bypass & dst.ready;
    assign src_bypass.ready = active &  use_bypass & dst.ready;

    assign fire = dst.valid & dst.ready;

    generate
        if (HAS_FRAME) begin : g_framed
            assign done = fire & dst.eop;
        end else begin : g_single
            assign done = fire;
        end
    endgenerate

endmodule

// File: rtl/ordered_path_merge.sv
// Rejoins the check and bypass paths into one in-order packet/meta/rule stream,
// draining one complete packet from the path named by each order entry.
module ordered_path_merge
    import ordered_path_merge_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int META_W  = META_W_DEF,
    parameter int EMPTY_W = EMPTY_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 ord_data,
    input  logic                 ord_valid,
    output logic                 ord_ready,

    ordered_path_merge_if.slave  c_pkt,
    ordered_path_merge_if.slave  c_meta,
    ordered_path_merge_if.slave  c_rule,
    ordered_path_merge_if.slave  b_pkt,
    ordered_path_merge_if.slave  b_meta,
    ordered_path_merge_if.slave  b_rule,

    ordered_path_merge_if.master o_pkt,
    ordered_path_merge_if.master o_meta,
    ordered_path_merge_if.master o_rule,

    output logic [31:0]          stats_pkt_check,
    output logic [31:0]          stats_pkt_bypass,
    output logic [31:0]          stats_stall
);

    state_t      state;
    state_t      state_next;
    logic        sel;
    logic        meta_done;
    logic        pkt_done;
    logic        rule_done;

    logic        active_meta;
    logic        active_pkt;
    logic        active_rule;
    logic        meta_fire;
    logic        pkt_fire;
    logic        rule_fire;
    logic        meta_fin;
    logic        pkt_fin;
    logic        rule_fin;

    logic        in_xfer;
    logic        pop;
    logic        all_done;
    logic        complete;
    logic        stall;

    logic [31:0] cnt_check;
    logic [31:0] cnt_bypass;
    logic [31:0] cnt_stall;

    assign in_xfer = rst_n & (state == ST_XFER);

    assign active_meta = in_xfer & ~meta_done;
    assign active_pkt  = in_xfer & ~pkt_done;
    assign active_rule = in_xfer & ~rule_done;

    ordered_path_merge_path_mux_ch #(
        .W         (META_W),
        .EW        (EMPTY_W),
        .HAS_FRAME (1'b0)
    ) u_meta_mux (
        .sel        (sel),
        .active     (active_meta),
        .src_check  (c_meta),
        .src_bypass (b_meta),
        .dst        (o_meta),
        .fire       (meta_fire),
        .done       (meta_fin)
    );

    ordered_path_merge_path_mux_ch #(
        .W         (DATA_W),
        .EW        (EMPTY_W),
        .HAS_FRAME (1'b1)
    ) u_pkt_mux (
        .sel        (sel),
        .active     (active_pkt),
        .src_check  (c_pkt),
        .src_bypass (b_pkt),
        .dst        (o_pkt),
        .fire       (pkt_fire),
        .done       (pkt_fin)
    );

    ordered_path_merge_path_mux_ch #(
        .W         (DATA_W),
        .EW        (EMPTY_W),
        .HAS_FRAME (1'b1)
    ) u_rule_mux (
        .sel        (sel),
        .active     (active_rule),
        .src_check  (c_rule),
        .src_bypass (b_rule),
        .dst        (o_rule),
        .fire       (rule_fire),
        .done       (rule_fin)
    );

    // A channel that finishes this cycle counts as done, so three final beats together close the packet.
    assign all_done = (meta_done | meta_fin) & (pkt_done | pkt_fin) & (rule_done | rule_fin);
    assign complete = in_xfer & all_done;
    assign stall    = in_xfer & ~(meta_fire | pkt_fire | rule_fire);
    assign pop      = ord_ready & ord_valid;

    always_comb begin
        state_next = state;
        ord_ready  = 1'b0;
        case (state)
            ST_IDLE: begin
                ord_ready = rst_n;
                if (ord_valid && rst_n) begin
                    state_next = ST_XFER;
                end
            end
            ST_XFER: begin
                if (all_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sel       <= PATH_CHECK;
            meta_done <= 1'b0;
            pkt_done  <= 1'b0;
            rule_done <= 1'b0;
        end else begin
            state <= state_next;
            if (pop) begin
                sel       <= ord_data;
                meta_done <= 1'b0;
                pkt_done  <= 1'b0;
                rule_done <= 1'b0;
            end else if (in_xfer) begin
                if (meta_fin) meta_done <= 1'b1;
                if (pkt_fin)  pkt_done  <= 1'b1;
                if (rule_fin) rule_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_check  <= 32'd0;
            cnt_bypass <= 32'd0;
            cnt_stall  <= 32'd0;
        end else begin
            if (complete) begin
                if (sel == PATH_CHECK) begin
                    cnt_check <= wrap_inc(cnt_check);
                end else begin
                    cnt_bypass <= wrap_inc(cnt_bypass);
                end
            end
            if (stall) begin
                cnt_stall <= wrap_inc(cnt_stall);
            end
        end
    end

    assign stats_pkt_check  = cnt_check;
    assign stats_pkt_bypass = cnt_bypass;
    assign stats_stall      = cnt_stall;

endmodule

// File: tb/tb_ordered_path_merge.sv
// Directed bench for ordered_path_merge: inputs change on the falling edge,
// outputs are compared 1 ns later, well before the next rising edge.
module tb_ordered_path_merge;
    import ordered_path_merge_pkg::*;

    localparam int DW = 512;
    localparam int MW = $bits(metadata_t);
    localparam int EW = 6;

    logic clk;
    logic rst_n;
    logic ord_data;
    logic ord_valid;
    logic ord_ready;
    logic [31:0] stats_pkt_check;
    logic [31:0] stats_pkt_bypass;
    logic [31:0] stats_stall;

    int tests_run  = 0;
    int fail_count = 0;
    int proto_errs = 0;
    logic in_pkt = 1'b0;

    ordered_path_merge_if #(.DW(DW), .EW(EW)) c_pkt_if  ();
    ordered_path_merge_if #(.DW(MW), .EW(EW)) c_meta_if ();
    ordered_path_merge_if #(.DW(DW), .EW(EW)) c_rule_if ();
    ordered_path_merge_if #(.DW(DW), .EW(EW)) b_pkt_if  ();
    ordered_path_merge_if #(.DW(MW), .EW(EW)) b_meta_if ();
    ordered_path_merge_if #(.DW(DW), .EW(EW)) b_rule_if ();
    ordered_path_merge_if #(.DW(DW), .EW(EW)) o_pkt_if  ();
    ordered_path_merge_if #(.DW(MW), .EW(EW)) o_meta_if ();
    ordered_path_merge_if #(.DW(DW), .EW(EW)) o_rule_if ();

    ordered_path_merge #(.DATA_W(DW), .META_W(MW), .EMPTY_W(EW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ord_data         (ord_data),
        .ord_valid        (ord_valid),
        .ord_ready        (ord_ready),
        .c_pkt            (c_pkt_if),
        .c_meta           (c_meta_if),
        .c_rule           (c_rule_if),
        .b_pkt            (b_pkt_if),
        .b_meta           (b_meta_if),
        .b_rule           (b_rule_if),
        .o_pkt            (o_pkt_if),
        .o_meta           (o_meta_if),
        .o_rule           (o_rule_if),
        .stats_pkt_check  (stats_pkt_check),
        .stats_pkt_bypass (stats_pkt_bypass),
        .stats_stall      (stats_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A merged packet must never show a second sop before its eop.
    always begin
        @(negedge clk);
        #4;
        if (!rst_n) begin
            in_pkt = 1'b0;
        end else if (o_pkt_if.valid && o_pkt_if.ready) begin
            if (o_pkt_if.sop && in_pkt) proto_errs++;
            in_pkt = !o_pkt_if.eop;
        end
    end

    task automatic check_output(input string tag, input logic [DW-1:0] observed,
                                input logic [DW-1:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic apply_pkt(input logic path, input logic v, input logic [DW-1:0] d,
                             input logic s, input logic e, input logic [EW-1:0] em);
        if (path == PATH_CHECK) begin
            c_pkt_if.valid = v; c_pkt_if.data = d; c_pkt_if.sop = s;
            c_pkt_if.eop = e; c_pkt_if.empty = em;
        end else begin
            b_pkt_if.valid = v; b_pkt_if.data = d; b_pkt_if.sop = s;
            b_pkt_if.eop = e; b_pkt_if.empty = em;
        end
    endtask

    task automatic apply_meta(input logic path, input logic v, input logic [MW-1:0] d);
        if (path == PATH_CHECK) begin
            c_meta_if.valid = v; c_meta_if.data = d;
        end else begin
            b_meta_if.valid = v; b_meta_if.data = d;
        end
    endtask

    task automatic apply_rule(input logic path, input logic v, input logic [DW-1:0] d,
                              input logic s, input logic e);
        if (path == PATH_CHECK) begin
            c_rule_if.valid = v; c_rule_if.data = d; c_rule_if.sop = s; c_rule_if.eop = e;
        end else begin
            b_rule_if.valid = v; b_rule_if.data = d; b_rule_if.sop = s; b_rule_if.eop = e;
        end
    endtask

    task automatic apply_stimulus_idle();
        for (int p = 0; p < 2; p++) begin
            apply_pkt(p[0], 1'b0, '0, 1'b0, 1'b0, '0);
            apply_meta(p[0], 1'b0, '0);
            apply_rule(p[0], 1'b0, '0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ord_data = 1'b0;
        ord_valid = 1'b0;
        apply_stimulus_idle();
        c_meta_if.sop = 1'b0; c_meta_if.eop = 1'b0; c_meta_if.empty = '0;
        b_meta_if.sop = 1'b0; b_meta_if.eop = 1'b0; b_meta_if.empty = '0;
        c_rule_if.empty = '0; b_rule_if.empty = '0;
        o_pkt_if.ready = 1'b1;
        o_meta_if.ready = 1'b1;
        o_rule_if.ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_output("rst_ord_ready", ord_ready, 1'b0);
        check_output("rst_pkt_valid", o_pkt_if.valid, 1'b0);
        check_output("rst_meta_valid", o_meta_if.valid, 1'b0);
        check_output("rst_rule_valid", o_rule_if.valid, 1'b0);
        check_output("rst_c_pkt_ready", c_pkt_if.ready, 1'b0);
        check_output("rst_stats_check", stats_pkt_check, 32'd0);
        check_output("rst_stats_bypass", stats_pkt_bypass, 32'd0);
        check_output("rst_stats_stall", stats_stall, 32'd0);

        // Order {0,1}: 3-beat check packet, then 1-beat bypass packet
        @(negedge clk);
        rst_n = 1'b1;
        ord_valid = 1'b1; ord_data = PATH_CHECK;
        apply_meta(PATH_CHECK, 1'b1, 48'hA0A0_0000_0001);
        apply_pkt(PATH_CHECK, 1'b1, 512'h100, 1'b1, 1'b0, 6'd0);
        apply_rule(PATH_CHECK, 1'b1, 512'h200, 1'b1, 1'b1);
        #1;
        check_output("idle_ord_ready", ord_ready, 1'b1);
        check_output("idle_no_pkt_valid", o_pkt_if.valid, 1'b0);
        check_output("idle_no_c_pkt_ready", c_pkt_if.ready, 1'b0);

        @(negedge clk);
        ord_data = PATH_BYPASS;
        #1;
        check_output("xfer_ord_ready", ord_ready, 1'b0);
        check_output("a_pkt_beat0", o_pkt_if.data, 512'h100);
        check_output("a_pkt_sop0", o_pkt_if.sop, 1'b1);
        check_output("a_meta_m0", o_meta_if.data, 48'hA0A0_0000_0001);
        check_output("a_rule_valid", o_rule_if.valid, 1'b1);
        check_output("a_b_pkt_ready", b_pkt_if.ready, 1'b0);
        check_output("a_c_pkt_ready", c_pkt_if.ready, 1'b1);

        @(negedge clk);
        apply_meta(PATH_CHECK, 1'b1, 48'hDEAD_BEEF_0000);
        apply_pkt(PATH_CHECK, 1'b1, 512'h101, 1'b0, 1'b0, 6'd0);
        apply_rule(PATH_CHECK, 1'b0, '0, 1'b0, 1'b0);
        #1;
        check_output("a_meta_done_gated", o_meta_if.valid, 1'b0);
        check_output("a_c_meta_ready_gated", c_meta_if.ready, 1'b0);
        check_output("a_pkt_beat1", o_pkt_if.data, 512'h101);

        @(negedge clk);
        apply_meta(PATH_CHECK, 1'b0, '0);
        apply_pkt(PATH_CHECK, 1'b1, 512'h102, 1'b0, 1'b1, 6'd5);
        #1;
        check_output("a_pkt_eop", o_pkt_if.eop, 1'b1);
        check_output("a_pkt_empty", o_pkt_if.empty, 6'd5);

        @(negedge clk);
        apply_pkt(PATH_CHECK, 1'b0, '0, 1'b0, 1'b0, 6'd0);
        apply_meta(PATH_BYPASS, 1'b1, 48'hB1B1_0000_0002);
        apply_pkt(PATH_BYPASS, 1'b1, 512'h300, 1'b1, 1'b1, 6'h3F);
        apply_rule(PATH_BYPASS, 1'b1, 512'h400, 1'b1, 1'b0);
        #1;
        check_output("a_stats_check_1", stats_pkt_check, 32'd1);
        check_output("a_stats_bypass_0", stats_pkt_bypass, 32'd0);
        check_output("a_bubble_ord_ready", ord_ready, 1'b1);
        check_output("a_bubble_pkt_valid", o_pkt_if.valid, 1'b0);

        @(negedge clk);
        ord_valid = 1'b0;
        #1;
        check_output("b_pkt_data", o_pkt_if.data, 512'h300);
        check_output("b_pkt_empty", o_pkt_if.empty, 6'h3F);
        check_output("b_meta_m1", o_meta_if.data, 48'hB1B1_0000_0002);
        check_output("b_b_pkt_ready", b_pkt_if.ready, 1'b1);
        check_output("b_c_pkt_ready", c_pkt_if.ready, 1'b0);

        @(negedge clk);
        apply_pkt(PATH_BYPASS, 1'b0, '0, 1'b0, 1'b0, 6'd0);
        apply_meta(PATH_BYPASS, 1'b0, '0);
        apply_rule(PATH_BYPASS, 1'b1, 512'h401, 1'b0, 1'b1);
        #1;
        check_output("b_rule_beat1", o_rule_if.data, 512'h401);
        check_output("b_rule_eop", o_rule_if.eop, 1'b1);

        @(negedge clk);
        apply_rule(PATH_BYPASS, 1'b0, '0, 1'b0, 1'b0);
        #1;
        check_output("b_stats_bypass_1", stats_pkt_bypass, 32'd1);
        check_output("b_stats_stall_0", stats_stall, 32'd0);

        // Bypass data waiting while a check packet is expected
        @(negedge clk);
        ord_valid = 1'b1; ord_data = PATH_CHECK;
        apply_meta(PATH_BYPASS, 1'b1, 48'h5555_0000_0005);
        apply_pkt(PATH_BYPASS, 1'b1, 512'h500, 1'b1, 1'b1, 6'd0);
        apply_rule(PATH_BYPASS, 1'b1, 512'h501, 1'b1, 1'b1);
        @(negedge clk);
        ord_valid = 1'b0;
        #1;
        check_output("s_b_pkt_ready", b_pkt_if.ready, 1'b0);
        check_output("s_b_meta_ready", b_meta_if.ready, 1'b0);
        check_output("s_pkt_valid", o_pkt_if.valid, 1'b0);
        check_output("s_stall_start", stats_stall, 32'd0);
        repeat (3) @(negedge clk);
        apply_stimulus_idle();
        apply_meta(PATH_CHECK, 1'b1, 48'hC3C3_0000_0003);
        apply_pkt(PATH_CHECK, 1'b1, 512'h600, 1'b1, 1'b1, 6'd0);
        apply_rule(PATH_CHECK, 1'b1, 512'h700, 1'b1, 1'b1);
        #1;
        check_output("s_stall_3", stats_stall, 32'd3);
        check_output("s_pkt_valid_now", o_pkt_if.valid, 1'b1);

        // All three channels finished in one cycle
        @(negedge clk);
        apply_stimulus_idle();
        #1;
        check_output("same_cycle_ord_ready", ord_ready, 1'b1);
        check_output("same_cycle_stats_check", stats_pkt_check, 32'd2);
        check_output("same_cycle_stall_held", stats_stall, 32'd3);

        // Downstream ready toggling on a 4-beat packet
        @(negedge clk);
        ord_valid = 1'b1; ord_data = PATH_CHECK;
        apply_meta(PATH_CHECK, 1'b1, 48'hC4C4_0000_0004);
        apply_pkt(PATH_CHECK, 1'b1, 512'h800, 1'b1, 1'b0, 6'd0);
        apply_rule(PATH_CHECK, 1'b1, 512'h900, 1'b1, 1'b1);
        @(negedge clk);
        ord_valid = 1'b0;
        #1;
        check_output("t_beat0", o_pkt_if.data, 512'h800);
        @(negedge clk);
        apply_meta(PATH_CHECK, 1'b0, '0);
        apply_rule(PATH_CHECK, 1'b0, '0, 1'b0, 1'b0);
        apply_pkt(PATH_CHECK, 1'b1, 512'h801, 1'b0, 1'b0, 6'd0);
        o_pkt_if.ready = 1'b0;
        #1;
        check_output("t_hold_c_ready", c_pkt_if.ready, 1'b0);
        check_output("t_hold_valid", o_pkt_if.valid, 1'b1);
        @(negedge clk);
        o_pkt_if.ready = 1'b1;
        #1;
        check_output("t_beat1", o_pkt_if.data, 512'h801);
        @(negedge clk);
        apply_pkt(PATH_CHECK, 1'b1, 512'h802, 1'b0, 1'b0, 6'd0);
        o_pkt_if.ready = 1'b0;
        #1;
        check_output("t_still_xfer", ord_ready, 1'b0);
        @(negedge clk);
        o_pkt_if.ready = 1'b1;
        #1;
        check_output("t_beat2", o_pkt_if.data, 512'h802);
        @(negedge clk);
        apply_pkt(PATH_CHECK, 1'b1, 512'h803, 1'b0, 1'b1, 6'd2);
        o_pkt_if.ready = 1'b0;
        #1;
        check_output("t_rule_done_wait_pkt", ord_ready, 1'b0);
        @(negedge clk);
        o_pkt_if.ready = 1'b1;
        #1;
        check_output("t_beat3", o_pkt_if.data, 512'h803);
        check_output("t_beat3_eop", o_pkt_if.eop, 1'b1);
        @(negedge clk);
        apply_stimulus_idle();
        #1;
        check_output("t_back_idle", ord_ready, 1'b1);
        check_output("t_stats_check_3", stats_pkt_check, 32'd3);
        check_output("t_stats_stall_6", stats_stall, 32'd6);

        // Reset in the middle of a packet (beat 2 of 4)
        @(negedge clk);
        ord_valid = 1'b1; ord_data = PATH_CHECK;
        apply_meta(PATH_CHECK, 1'b1, 48'hC5C5_0000_0005);
        apply_pkt(PATH_CHECK, 1'b1, 512'hA00, 1'b1, 1'b0, 6'd0);
        apply_rule(PATH_CHECK, 1'b1, 512'hB00, 1'b1, 1'b0);
        @(negedge clk);
        ord_valid = 1'b0;
        @(negedge clk);
        apply_meta(PATH_CHECK, 1'b0, '0);
        apply_pkt(PATH_CHECK, 1'b1, 512'hA01, 1'b0, 1'b0, 6'd0);
        apply_rule(PATH_CHECK, 1'b1, 512'hB01, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_output("r_pkt_valid", o_pkt_if.valid, 1'b0);
        check_output("r_meta_valid", o_meta_if.valid, 1'b0);
        check_output("r_rule_valid", o_rule_if.valid, 1'b0);
        check_output("r_c_pkt_ready", c_pkt_if.ready, 1'b0);
        check_output("r_ord_ready", ord_ready, 1'b0);
        check_output("r_stats_check", stats_pkt_check, 32'd0);
        check_output("r_stats_stall", stats_stall, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus_idle();
        ord_valid = 1'b1; ord_data = PATH_BYPASS;
        apply_meta(PATH_BYPASS, 1'b1, 48'hB6B6_0000_0006);
        apply_pkt(PATH_BYPASS, 1'b1, 512'hC00, 1'b1, 1'b1, 6'd0);
        apply_rule(PATH_BYPASS, 1'b1, 512'hD00, 1'b1, 1'b1);
        #1;
        check_output("r_release_ord_ready", ord_ready, 1'b1);
        @(negedge clk);
        ord_valid = 1'b0;
        #1;
        check_output("r_new_pkt", o_pkt_if.data, 512'hC00);
        check_output("r_new_meta", o_meta_if.data, 48'hB6B6_0000_0006);
        @(negedge clk);
        apply_stimulus_idle();
        #1;
        check_output("r_stats_bypass_1", stats_pkt_bypass, 32'd1);
        check_output("r_idle_again", ord_ready, 1'b1);

        // Check counter wrap from all-ones
        @(negedge clk);
        force dut.cnt_check = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.cnt_check;
        ord_valid = 1'b1; ord_data = PATH_CHECK;
        apply_meta(PATH_CHECK, 1'b1, 48'hC7C7_0000_0007);
        apply_pkt(PATH_CHECK, 1'b1, 512'hE00, 1'b1, 1'b1, 6'd0);
        apply_rule(PATH_CHECK, 1'b1, 512'hF00, 1'b1, 1'b1);
        #1;
        check_output("w_preload", stats_pkt_check, 32'hFFFF_FFFF);
        @(negedge clk);
        ord_valid = 1'b0;
        @(negedge clk);
        apply_stimulus_idle();
        #1;
        check_output("w_wrapped", stats_pkt_check, 32'd0);
        check_output("w_bypass_kept", stats_pkt_bypass, 32'd1);

        check_output("proto_sop_mid_packet", proto_errs, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
